swarm_cfg_responder: RTL and testbench

- AXI-Lite (OCL) slave that answers host reads of the compile-time Swarm build configuration.
- Also holds the small set of runtime-writable config registers (CQ size limit, logging mask, scratch).
- One instance per tile, placed behind the OCL splitter.
- Host software uses it to check the build VERSION and parameters before loading an application.

---
 rtl/swarm_cfg_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_swarm_cfg_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swarm_cfg_responder.sv
`timescale 1ns/1ps
// swarm_cfg_responder
// AXI-Lite (OCL) slave that reports the compile-time Swarm build configuration
// and holds the runtime-writable CQ_SIZE, LOG_MASK and SCRATCH registers.
// Optional feature macro: SWARM_CFG_CYCLE_CNT_EN adds a free-running 64-bit
// cycle counter readable at 0x2C (low word, snapshots high) and 0x30 (high).
module swarm_cfg_responder #(
  parameter int         ADDR_W              = 8,
  parameter int         VERSION_P           = 10,
  parameter int         N_TILES_P           = 1,
  parameter int         N_THREADS_P         = 32,
  parameter int         TS_WIDTH_P          = 32,
  parameter int         LOG_CQ_SLICE_SIZE_P = 7,
  parameter int         LOG_TQ_SIZE_P       = 12,
  parameter logic [7:0] FLAGS_P             = 8'h00
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [ADDR_W-1:0]            s_awaddr,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  input  logic [31:0]                  s_wdata,
  input  logic [3:0]                   s_wstrb,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  output logic [1:0]                   s_bresp,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  input  logic [ADDR_W-1:0]            s_araddr,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [31:0]                  s_rdata,
  output logic [1:0]                   s_rresp,
  output logic [LOG_CQ_SLICE_SIZE_P:0] cq_size,
  output logic [31:0]                  log_mask
);

  localparam int CQW = LOG_CQ_SLICE_SIZE_P + 1;
  localparam int IW  = ADDR_W - 2;
  localparam logic [CQW-1:0] CQ_MAX   = CQW'(1) << LOG_CQ_SLICE_SIZE_P;
  localparam logic [31:0]    CQ_MAX32 = 32'(CQ_MAX);
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  // Word indices (byte address >> 2) of the register map.
  localparam logic [IW-1:0] IDX_VERSION = IW'(0);
  localparam logic [IW-1:0] IDX_NTILES  = IW'(1);
  localparam logic [IW-1:0] IDX_NTHR    = IW'(2);
  localparam logic [IW-1:0] IDX_WIDTHS  = IW'(3);
  localparam logic [IW-1:0] IDX_FLAGS   = IW'(4);
  localparam logic [IW-1:0] IDX_CQ      = IW'(8);
  localparam logic [IW-1:0] IDX_MASK    = IW'(9);
  localparam logic [IW-1:0] IDX_SCRATCH = IW'(10);
`ifdef SWARM_CFG_CYCLE_CNT_EN
  localparam logic [IW-1:0] IDX_CYC_LO  = IW'(11);
  localparam logic [IW-1:0] IDX_CYC_HI  = IW'(12);
`endif

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_RESP } rstate_e;

  // Byte-enable merge of new write data into the current register value.
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  st);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = st[b] ? wd[8*b +: 8] : cur[8*b +: 8];
    return res;
  endfunction

  // CQ_SIZE must stay within [1, 1<<LOG]; clamping happens after the merge.
  function automatic logic [CQW-1:0] cq_clamp(input logic [31:0] m);
    if (m == 32'd0)          return CQW'(1);
    else if (m > CQ_MAX32)   return CQ_MAX;
    else                     return m[CQW-1:0];
  endfunction

  wstate_e         wstate_q;
  rstate_e         rstate_q;
  logic            awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]      bresp_q, rresp_q;
  logic [31:0]     rdata_q;
  logic            aw_have_q, w_have_q;
  logic [IW-1:0]   awidx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [CQW-1:0]  cq_q, cq_d;
  logic [31:0]     mask_q, mask_d, scratch_q, scratch_d;
  logic            wr_slverr;
  logic [31:0]     rd_data_d;
  logic [1:0]      rd_resp_d;

  // A beat counts as present if captured earlier or handshaking this cycle,
  // so a same-cycle AW+W pair commits on the handshake edge.
  logic            aw_ok, w_ok;
  logic [IW-1:0]   awidx_d;
  logic [31:0]     wdata_d;
  logic [3:0]      wstrb_d;
  assign aw_ok   = aw_have_q | (s_awvalid & awready_q);
  assign w_ok    = w_have_q  | (s_wvalid  & wready_q);
  assign awidx_d = aw_have_q ? awidx_q : s_awaddr[ADDR_W-1:2];
  assign wdata_d = w_have_q  ? wdata_q : s_wdata;
  assign wstrb_d = w_have_q  ? wstrb_q : s_wstrb;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

`ifdef SWARM_CFG_CYCLE_CNT_EN
  logic [63:0] cyc_q;
  logic [31:0] cyc_hi_q;

  // Free-running cycle counter, wraps naturally at 2^64.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_q + 64'd1;
  end

  // Reading the low word freezes the high word so the pair is coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_hi_q <= '0;
    else if (rstate_q == R_IDLE && s_arvalid && arready_q &&
             s_araddr[ADDR_W-1:2] == IDX_CYC_LO)
      cyc_hi_q <= cyc_q[63:32];
  end
`endif

  // Next register values for the pending write; unmapped/RO targets flag SLVERR.
  always_comb begin
    wr_slverr = 1'b0;
    cq_d      = cq_q;
    mask_d    = mask_q;
    scratch_d = scratch_q;
    case (awidx_d)
      IDX_CQ:      cq_d      = cq_clamp(byte_merge(32'(cq_q), wdata_d, wstrb_d));
      IDX_MASK:    mask_d    = byte_merge(mask_q, wdata_d, wstrb_d);
      IDX_SCRATCH: scratch_d = byte_merge(scratch_q, wdata_d, wstrb_d);
      default:     wr_slverr = 1'b1;
    endcase
  end

  // Read decode from the current (pre-write) register contents.
  always_comb begin
    rd_data_d = '0;
    rd_resp_d = RESP_OKAY;
    case (s_araddr[ADDR_W-1:2])
      IDX_VERSION: rd_data_d = 32'(VERSION_P);
      IDX_NTILES:  rd_data_d = 32'(N_TILES_P);
      IDX_NTHR:    rd_data_d = 32'(N_THREADS_P);
      IDX_WIDTHS:  rd_data_d = {8'(LOG_CQ_SLICE_SIZE_P), 8'(LOG_TQ_SIZE_P), 8'd0, 8'(TS_WIDTH_P)};
      IDX_FLAGS:   rd_data_d = 32'(FLAGS_P);
      IDX_CQ:      rd_data_d = 32'(cq_q);
      IDX_MASK:    rd_data_d = mask_q;
      IDX_SCRATCH: rd_data_d = scratch_q;
`ifdef SWARM_CFG_CYCLE_CNT_EN
      IDX_CYC_LO:  rd_data_d = cyc_q[31:0];
      IDX_CYC_HI:  rd_data_d = cyc_hi_q;
`endif
      default:     rd_resp_d = RESP_SLVERR;
    endcase
  end

  // Write channel FSM: collect AW and W in any order, commit, then respond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cq_q      <= CQ_MAX;
      mask_q    <= '0;
      scratch_q <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (s_awvalid && awready_q) begin
            awidx_q   <= s_awaddr[ADDR_W-1:2];
            aw_have_q <= 1'b1;
            awready_q <= 1'b0;
          end
          if (s_wvalid && wready_q) begin
            wdata_q  <= s_wdata;
            wstrb_q  <= s_wstrb;
            w_have_q <= 1'b1;
            wready_q <= 1'b0;
          end
          if (aw_ok && w_ok) begin
            cq_q      <= cq_d;
            mask_q    <= mask_d;
            scratch_q <= scratch_d;
            bresp_q   <= wr_slverr ? RESP_SLVERR : RESP_OKAY;
            bvalid_q  <= 1'b1;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            wstate_q  <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: one-cycle registered response, held until rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (s_arvalid && arready_q) begin
            rdata_q   <= rd_data_d;
            rresp_q   <= rd_resp_d;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign cq_size   = cq_q;
  assign log_mask  = mask_q;

endmodule

// File: tb/tb_swarm_cfg_responder.sv
`timescale 1ns/1ps
// Self-checking bench for swarm_cfg_responder: a register-map model tracks the
// expected contents, a monitor compares every cycle, and directed transactions
// pin the model with hand-computed literals.
module tb_swarm_cfg_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [7:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata, s_rdata, log_mask;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic [7:0]  cq_size;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  swarm_cfg_responder dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .cq_size(cq_size), .log_mask(log_mask)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- register-map model ----------------
  logic [31:0] m_cq, m_mask, m_scr;

  function automatic void model_reset();
    m_cq = 32'd128; m_mask = '0; m_scr = '0;
  endfunction

  function automatic void model_read(input logic [7:0] a, output logic [31:0] d,
                                     output logic [1:0] r, output bit skip);
    d = '0; r = 2'b00; skip = 1'b0;
    case (a & 8'hFC)
      8'h00: d = 32'd10;
      8'h04: d = 32'd1;
      8'h08: d = 32'd32;
      8'h0C: d = {8'd7, 8'd12, 8'd0, 8'd32};
      8'h10: d = 32'd0;
      8'h20: d = m_cq;
      8'h24: d = m_mask;
      8'h28: d = m_scr;
`ifdef SWARM_CFG_CYCLE_CNT_EN
      8'h2C, 8'h30: skip = 1'b1;
`endif
      default: r = 2'b10;
    endcase
  endfunction

  function automatic void model_write(input logic [7:0] a, input logic [31:0] d,
                                      input logic [3:0] st, output logic [1:0] resp);
    logic [31:0] cur, mg;
    case (a & 8'hFC)
      8'h20: cur = m_cq;
      8'h24: cur = m_mask;
      8'h28: cur = m_scr;
      default: begin resp = 2'b10; return; end
    endcase
    for (int b = 0; b < 4; b++) mg[8*b +: 8] = st[b] ? d[8*b +: 8] : cur[8*b +: 8];
    case (a & 8'hFC)
      8'h20: m_cq = (mg == 0) ? 32'd1 : (mg > 32'd128) ? 32'd128 : mg;
      8'h24: m_mask = mg;
      default: m_scr = mg;
    endcase
    resp = 2'b00;
  endfunction

  typedef struct { logic [31:0] d; logic [1:0] r; bit skip; } rexp_t;
  typedef struct { logic [31:0] d; logic [3:0] s; } wbeat_t;
  rexp_t      r_q[$];
  wbeat_t     w_q[$];
  logic [7:0] aw_q[$];

  // Monitor: sampled mid-cycle, sees exactly what the next rising edge samples.
  initial begin : monitor
    logic [1:0]  exp_bresp;
    bit          b_seen, sk;
    logic [31:0] d;
    logic [1:0]  r;
    logic [7:0]  a;
    rexp_t       re;
    wbeat_t      wb;
    exp_bresp = '0; b_seen = 0;
    model_reset();
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        aw_q.delete(); w_q.delete(); r_q.delete();
        model_reset(); b_seen = 0;
        continue;
      end
      if (s_bvalid && !b_seen) begin
        chk("bvalid_has_beats", 64'(aw_q.size() > 0 && w_q.size() > 0), 64'd1);
        if (aw_q.size() > 0 && w_q.size() > 0) begin
          a = aw_q.pop_front(); wb = w_q.pop_front();
          model_write(a, wb.d, wb.s, exp_bresp);
        end
        b_seen = 1;
      end else if (!s_bvalid && aw_q.size() > 0 && w_q.size() > 0) begin
        chk("bvalid_latency", 64'(s_bvalid), 64'd1);
      end
      if (s_bvalid) begin
        chk("bresp", 64'(s_bresp), 64'(exp_bresp));
        if (s_bready) b_seen = 0;
      end
      if (s_rvalid) begin
        chk("rvalid_has_req", 64'(r_q.size() > 0), 64'd1);
        if (r_q.size() > 0) begin
          re = r_q[0];
          if (!re.skip) chk("rdata", 64'(s_rdata), 64'(re.d));
          chk("rresp", 64'(s_rresp), 64'(re.r));
          if (s_rready) void'(r_q.pop_front());
        end
      end else if (r_q.size() > 0) begin
        chk("rvalid_latency", 64'(s_rvalid), 64'd1);
      end
      chk("cq_size", 64'(cq_size), 64'(m_cq));
      chk("log_mask", 64'(log_mask), 64'(m_mask));
      if (s_arvalid && s_arready) begin
        model_read(s_araddr, d, r, sk);
        re.d = d; re.r = r; re.skip = sk;
        r_q.push_back(re);
      end
      if (s_awvalid && s_awready) aw_q.push_back(s_awaddr);
      if (s_wvalid && s_wready) begin
        wb.d = s_wdata; wb.s = s_wstrb;
        w_q.push_back(wb);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_read(input logic [7:0] a, output logic [31:0] d,
                         output logic [1:0] r, output int lat);
    int n;
    d = '0; r = '0; lat = 0;
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = a;
    n = 0;
    while (!s_arready && n < 50) begin @(negedge clk); n++; end
    if (!s_arready) begin
      chk("arready_timeout", 64'(s_arready), 64'd1);
      s_arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    s_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 50) begin @(negedge clk); lat++; end
    if (!s_rvalid) chk("rvalid_timeout", 64'(s_rvalid), 64'd1);
    d = s_rdata; r = s_rresp;
  endtask

  task automatic send_aw(input logic [7:0] a);
    int n;
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = a;
    n = 0;
    while (!s_awready && n < 50) begin @(negedge clk); n++; end
    if (!s_awready) chk("awready_timeout", 64'(s_awready), 64'd1);
    @(negedge clk);
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] st);
    int n;
    @(negedge clk);
    s_wvalid = 1'b1; s_wdata = d; s_wstrb = st;
    n = 0;
    while (!s_wready && n < 50) begin @(negedge clk); n++; end
    if (!s_wready) chk("wready_timeout", 64'(s_wready), 64'd1);
    @(negedge clk);
    s_wvalid = 1'b0;
  endtask

  // dw/da: idle cycles before the W and AW beats; hold: cycles with bready low.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                          input int dw, input int da, input int hold,
                          output logic [1:0] resp, output int held);
    int n;
    s_bready = 1'b0;
    fork
      begin repeat (dw) @(negedge clk); send_w(d, st); end
      begin repeat (da) @(negedge clk); send_aw(a); end
    join
    n = 0;
    while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
    if (!s_bvalid) chk("bvalid_timeout", 64'(s_bvalid), 64'd1);
    resp = s_bresp; held = 0;
    repeat (hold) begin
      @(negedge clk);
      if (s_bvalid && s_bresp == resp) held++;
    end
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic [31:0] d, lo, hi, lo2;
    logic [1:0]  r;
    int          lat, held;
    rst = 1'b1;
    s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0;
    s_bready = 0; s_arvalid = 0; s_araddr = '0; s_rready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(s_awready), 64'd1);
    chk("rst_wready",  64'(s_wready),  64'd1);
    chk("rst_arready", 64'(s_arready), 64'd1);
    chk("rst_bvalid",  64'(s_bvalid),  64'd0);
    chk("rst_rvalid",  64'(s_rvalid),  64'd0);
    chk("rst_rdata",   64'(s_rdata),   64'd0);
    chk("rst_cq_size", 64'(cq_size),   64'd128);
    chk("rst_log_mask", 64'(log_mask), 64'd0);
    rst = 1'b0;

    do_read(8'h00, d, r, lat);
    chk("version", 64'(d), 64'd10); chk("version_resp", 64'(r), 64'd0); chk("read_latency", 64'(lat), 64'd1);
    do_read(8'h0C, d, r, lat);  chk("widths", 64'(d), 64'h070C0020);
    do_read(8'h08, d, r, lat);  chk("n_threads", 64'(d), 64'd32);
    do_read(8'h20, d, r, lat);  chk("cq_reset_read", 64'(d), 64'd128);

    do_write(8'h20, 32'd0, 4'hF, 0, 0, 0, r, held);
    chk("cq0_bresp", 64'(r), 64'd0); chk("cq0_clamp", 64'(cq_size), 64'd1);
    do_write(8'h20, 32'd500, 4'hF, 0, 0, 0, r, held);  chk("cq500_clamp", 64'(cq_size), 64'd128);
    do_write(8'h20, 32'd64, 4'hF, 0, 0, 0, r, held);   chk("cq64", 64'(cq_size), 64'd64);
    do_write(8'h20, 32'h0000_0100, 4'h2, 0, 0, 0, r, held); chk("cq_merge_over", 64'(cq_size), 64'd128);
    do_write(8'h20, 32'd129, 4'hF, 0, 0, 0, r, held);  chk("cq129", 64'(cq_size), 64'd128);
    do_write(8'h20, 32'd3, 4'hF, 0, 0, 0, r, held);    chk("cq3", 64'(cq_size), 64'd3);
    do_write(8'h20, 32'hFFFF_FF00, 4'h1, 0, 0, 0, r, held); chk("cq_merge_zero", 64'(cq_size), 64'd1);

    // W three cycles ahead of AW, response stalled by bready
    do_write(8'h24, 32'hA5A5_A5A5, 4'h3, 0, 3, 4, r, held);
    chk("mask_partial", 64'(log_mask), 64'h0000A5A5);
    chk("mask_bresp", 64'(r), 64'd0); chk("bvalid_held", 64'(held), 64'd4);
    do_read(8'h27, d, r, lat);  chk("mask_lsb_ignored", 64'(d), 64'h0000A5A5);

    // AW ahead of W
    do_write(8'h28, 32'hDEAD_BEEF, 4'hF, 2, 0, 1, r, held);
    do_read(8'h28, d, r, lat);  chk("scratch", 64'(d), 64'hDEADBEEF);

    do_write(8'h04, 32'd7, 4'hF, 0, 0, 0, r, held);    chk("ro_write_slverr", 64'(r), 64'd2);
    do_read(8'h04, d, r, lat);  chk("n_tiles", 64'(d), 64'd1); chk("n_tiles_resp", 64'(r), 64'd0);
    do_read(8'h3C, d, r, lat);  chk("unmapped_data", 64'(d), 64'd0); chk("unmapped_resp", 64'(r), 64'd2);
    do_write(8'h2C, 32'd1, 4'hF, 0, 0, 0, r, held);    chk("cyc_write_slverr", 64'(r), 64'd2);
`ifndef SWARM_CFG_CYCLE_CNT_EN
    do_read(8'h2C, d, r, lat);  chk("cyc_lo_absent", 64'(r), 64'd2); chk("cyc_lo_zero", 64'(d), 64'd0);
`endif

    // Read and write to the same register on the same edge: read sees old value
    fork
      begin
        logic [31:0] rd; logic [1:0] rr; int rl;
        do_read(8'h28, rd, rr, rl);
        chk("same_cycle_old", 64'(rd), 64'hDEADBEEF);
      end
      begin
        logic [1:0] wr; int wh;
        do_write(8'h28, 32'h1234_5678, 4'hF, 0, 0, 0, wr, wh);
      end
    join
    do_read(8'h28, d, r, lat);  chk("same_cycle_new", 64'(d), 64'h12345678);

    // Reset with an AW beat captured and no W: transaction is dropped
    @(negedge clk); s_awvalid = 1'b1; s_awaddr = 8'h28;
    @(negedge clk); s_awvalid = 1'b0;
    chk("aw_captured", 64'(s_awready), 64'd0);
    rst = 1'b1; #1;
    chk("async_rst_awready", 64'(s_awready), 64'd1);
    chk("async_rst_cq", 64'(cq_size), 64'd128);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin @(negedge clk); chk("no_bvalid_after_rst", 64'(s_bvalid), 64'd0); end
    do_read(8'h28, d, r, lat);  chk("scratch_after_rst", 64'(d), 64'd0);

`ifdef SWARM_CFG_CYCLE_CNT_EN
    repeat (985) @(negedge clk);
    do_read(8'h2C, lo, r, lat); chk("cyc_lo_resp", 64'(r), 64'd0);
    do_read(8'h30, hi, r, lat); chk("cyc_hi_resp", 64'(r), 64'd0);
    chk("cyc_hi_zero", 64'(hi), 64'd0);
    chk("cyc_lo_range", 64'(lo >= 32'd990 && lo <= 32'd1030), 64'd1);
    do_read(8'h2C, lo2, r, lat); chk("cyc_monotonic", 64'(lo2 > lo), 64'd1);
`else
    lo = '0; hi = '0; lo2 = '0;
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
